// File: rtl/mppt_po_ctrl.sv
// mppt_po_ctrl: perturb-and-observe MPPT controller driving the 8-bit dpwm duty
//   clk       system clock
//   rst       asynchronous reset, active-low
//   en        tracking enable; low aborts any transaction and forces a re-baseline
//   v_smp     panel voltage sample, unsigned
//   i_smp     panel current sample, unsigned
//   smp_valid one-cycle strobe qualifying v_smp/i_smp, honoured only in WAIT
//   duty      registered duty, always within [DUTY_MIN, DUTY_MAX]
//   duty_upd  one-cycle pulse when duty is written
//   dir       perturbation direction, 1 = increase duty
//   busy      high whenever the controller is not waiting for a sample
module mppt_po_ctrl #(
    parameter int unsigned VW        = 12,
    parameter int unsigned IW        = 12,
    parameter logic [7:0]  DUTY_INIT = 8'd128,
    parameter logic [7:0]  DUTY_MIN  = 8'd16,
    parameter logic [7:0]  DUTY_MAX  = 8'd240,
    parameter logic [7:0]  STEP      = 8'd2,
    parameter logic [15:0] SETTLE    = 16'd1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [VW-1:0] v_smp,
    input  logic [IW-1:0] i_smp,
    input  logic          smp_valid,
    output logic [7:0]    duty,
    output logic          duty_upd,
    output logic          dir,
    output logic          busy
);
    typedef enum logic [1:0] {S_WAIT, S_CALC, S_UPDATE, S_SETTLE} state_t;
    state_t              r_state, w_state_nxt;
    logic [VW-1:0]       r_v;
    logic [IW-1:0]       r_i;
    logic [VW+IW-1:0]    r_p_cur, r_p_prev, w_p;
    logic [7:0]          r_duty, w_duty_new;
    logic                r_dir, w_dir_new, w_dir_cmp, r_first, r_upd;
    logic [15:0]         r_cnt;
    logic [8:0]          w_up, w_dn_lim;
    assign w_p      = {{IW{1'b0}}, r_v} * {{VW{1'b0}}, r_i};
    assign duty     = r_duty;
    assign dir      = r_dir;
    assign duty_upd = r_upd;
    assign busy     = r_state != S_WAIT;
    always_comb begin
        w_state_nxt = r_state;
        // the first sample after reset or an enable drop has no valid reference power
        w_dir_cmp   = (!r_first && r_p_cur < r_p_prev) ? ~r_dir : r_dir;
        // 9-bit step arithmetic so the clamp tests can never wrap
        w_up        = {1'b0, r_duty} + {1'b0, STEP};
        w_dn_lim    = {1'b0, DUTY_MIN} + {1'b0, STEP};
        // hitting a clamp reverses direction regardless of the power comparison
        w_duty_new  = w_dir_cmp ? ((w_up >= {1'b0, DUTY_MAX}) ? DUTY_MAX : w_up[7:0])
                                : (({1'b0, r_duty} <= w_dn_lim) ? DUTY_MIN : r_duty - STEP);
        w_dir_new   = w_dir_cmp ? (w_up < {1'b0, DUTY_MAX}) : ({1'b0, r_duty} <= w_dn_lim);
        if (!en)
            w_state_nxt = S_WAIT;
        else
            case (r_state)
                S_WAIT:   w_state_nxt = smp_valid ? S_CALC : S_WAIT;
                S_CALC:   w_state_nxt = S_UPDATE;
                S_UPDATE: w_state_nxt = S_SETTLE;
                S_SETTLE: w_state_nxt = (r_cnt == SETTLE - 16'd1) ? S_WAIT : S_SETTLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_WAIT;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v      <= '0;
            r_i      <= '0;
            r_p_cur  <= '0;
            r_p_prev <= '0;
            r_duty   <= DUTY_INIT;
            r_dir    <= 1'b1;
            r_first  <= 1'b1;
            r_upd    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_upd <= 1'b0;
            if (!en)
                r_first <= 1'b1;
            case (r_state)
                S_WAIT: begin
                    if (en && smp_valid) begin
                        r_v <= v_smp;
                        r_i <= i_smp;
                    end
                end
                S_CALC:   r_p_cur <= w_p;
                S_UPDATE: begin
                    if (en) begin
                        r_duty   <= w_duty_new;
                        r_dir    <= w_dir_new;
                        r_p_prev <= r_p_cur;
                        r_first  <= 1'b0;
                        r_upd    <= 1'b1;
                    end
                end
                S_SETTLE: r_cnt <= (!en || r_cnt == SETTLE - 16'd1) ? '0 : r_cnt + 16'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_mppt_po_ctrl.sv
// tb_mppt_po_ctrl: randomized and directed check of mppt_po_ctrl against a transaction-level model
module tb_mppt_po_ctrl;
    localparam int STEP = 2, DMIN = 16, DMAX = 240;
    logic        clk = 1'b0;
    logic        rst, en, smp_valid;
    logic [11:0] v_smp, i_smp;
    logic [7:0]  duty [3];
    logic        duty_upd [3], dir [3], busy [3];
    int          m_duty [3];
    bit          m_dir [3], m_first [3];
    longint      m_prev [3];
    int          n_tests = 0, n_fail = 0;
    logic [11:0] last_v = 12'd0, last_i = 12'd0;
    always #5 clk = ~clk;
    mppt_po_ctrl #(.DUTY_INIT(8'd128), .SETTLE(16'd4)) dut_a (.clk(clk), .rst(rst), .en(en), .v_smp(v_smp), .i_smp(i_smp),
        .smp_valid(smp_valid), .duty(duty[0]), .duty_upd(duty_upd[0]), .dir(dir[0]), .busy(busy[0]));
    mppt_po_ctrl #(.DUTY_INIT(8'd236), .SETTLE(16'd4)) dut_b (.clk(clk), .rst(rst), .en(en), .v_smp(v_smp), .i_smp(i_smp),
        .smp_valid(smp_valid), .duty(duty[1]), .duty_upd(duty_upd[1]), .dir(dir[1]), .busy(busy[1]));
    mppt_po_ctrl #(.DUTY_INIT(8'd20), .SETTLE(16'd4)) dut_c (.clk(clk), .rst(rst), .en(en), .v_smp(v_smp), .i_smp(i_smp),
        .smp_valid(smp_valid), .duty(duty[2]), .duty_upd(duty_upd[2]), .dir(dir[2]), .busy(busy[2]));
    function automatic int init_of(int k);
        return (k == 0) ? 128 : (k == 1) ? 236 : 20;
    endfunction
    task automatic chk(string tag, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_duty[k]  = init_of(k);
            m_dir[k]   = 1'b1;
            m_prev[k]  = 0;
            m_first[k] = 1'b1;
        end
    endtask
    task automatic model_step(longint p);
        for (int k = 0; k < 3; k++) begin
            bit up;
            up = (!m_first[k] && p < m_prev[k]) ? !m_dir[k] : m_dir[k];
            if (up) begin
                if (m_duty[k] + STEP >= DMAX) begin m_duty[k] = DMAX; m_dir[k] = 1'b0; end
                else begin m_duty[k] = m_duty[k] + STEP; m_dir[k] = 1'b1; end
            end else begin
                if (m_duty[k] <= DMIN + STEP) begin m_duty[k] = DMIN; m_dir[k] = 1'b1; end
                else begin m_duty[k] = m_duty[k] - STEP; m_dir[k] = 1'b0; end
            end
            m_prev[k]  = p;
            m_first[k] = 1'b0;
        end
    endtask
    task automatic chk_state(string tag, int upd, int bsy);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.duty%0d", tag, k), int'(duty[k]), m_duty[k]);
            chk($sformatf("%s.dir%0d", tag, k), int'(dir[k]), int'(m_dir[k]));
            chk($sformatf("%s.upd%0d", tag, k), int'(duty_upd[k]), upd);
            chk($sformatf("%s.busy%0d", tag, k), int'(busy[k]), bsy);
        end
    endtask
    // full sample transaction; stray strobes land in CALC and SETTLE and must be dropped
    task automatic txn(logic [11:0] v, logic [11:0] i, bit stray);
        longint p;
        p = longint'(v) * longint'(i);
        last_v = v;
        last_i = i;
        v_smp = v; i_smp = i; smp_valid = 1'b1;
        tick();
        v_smp = 12'($urandom); i_smp = 12'($urandom); smp_valid = stray;
        chk_state("calc", 0, 1);
        tick();
        smp_valid = 1'b0;
        chk_state("upd_st", 0, 1);
        tick();
        model_step(p);
        chk_state("written", 1, 1);
        smp_valid = stray;
        tick();
        smp_valid = 1'b0;
        chk_state("settle", 0, 1);
        tick();
        tick();
        chk_state("settle_end", 0, 1);
        tick();
        chk_state("idle", 0, 0);
    endtask
    // en dropped while in CALC (stage 1) or UPDATE (stage 2)
    task automatic abort_txn(logic [11:0] v, logic [11:0] i, int stage);
        v_smp = v; i_smp = i; smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        if (stage == 2) tick();
        en = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) m_first[k] = 1'b1;
        chk_state("abort", 0, 0);
        en = 1'b1;
        tick();
        chk_state("abort_idle", 0, 0);
    endtask
    task automatic idle_en_low(int n);
        en = 1'b0;
        smp_valid = ($urandom_range(0, 1) == 1);
        repeat (n) tick();
        smp_valid = 1'b0;
        for (int k = 0; k < 3; k++) m_first[k] = 1'b1;
        chk_state("en_low", 0, 0);
        en = 1'b1;
    endtask
    task automatic do_reset(bit check_now);
        #2 rst = 1'b0;
        #1;
        if (check_now)
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("arst.duty%0d", k), int'(duty[k]), init_of(k));
                chk($sformatf("arst.busy%0d", k), int'(busy[k]), 0);
                chk($sformatf("arst.upd%0d", k), int'(duty_upd[k]), 0);
            end
        #2 rst = 1'b1;
        model_reset();
        tick();
    endtask
    initial begin
        int rise_i [4] = '{1000, 1100, 1200, 1300};
        int exp_b [4]  = '{238, 240, 238, 236};
        int dir_b [4]  = '{1, 0, 0, 0};
        int mir_i [5]  = '{1000, 900, 950, 1000, 1100};
        int exp_c [5]  = '{22, 20, 18, 16, 18};
        int dir_c [5]  = '{1, 0, 0, 1, 1};
        rst = 1'b0; en = 1'b0; smp_valid = 1'b0; v_smp = '0; i_smp = '0;
        model_reset();
        tick();
        tick();
        chk_state("reset", 0, 0);
        #2 rst = 1'b1;
        en = 1'b1;
        tick();
        txn(12'd1000, 12'd1000, 1'b1);
        chk("t1.duty", int'(duty[0]), 130);
        chk("t1.dir", int'(dir[0]), 1);
        txn(12'd1000, 12'd1100, 1'b1);
        chk("t2a.duty", int'(duty[0]), 132);
        txn(12'd1000, 12'd900, 1'b1);
        chk("t2b.duty", int'(duty[0]), 130);
        chk("t2b.dir", int'(dir[0]), 0);
        do_reset(1'b0);
        for (int n = 0; n < 4; n++) begin
            txn(12'd1000, 12'(rise_i[n]), 1'b0);
            chk($sformatf("t4max.duty%0d", n), int'(duty[1]), exp_b[n]);
            chk($sformatf("t4max.dir%0d", n), int'(dir[1]), dir_b[n]);
        end
        do_reset(1'b0);
        for (int n = 0; n < 5; n++) begin
            txn(12'd1000, 12'(mir_i[n]), 1'b0);
            chk($sformatf("t4min.duty%0d", n), int'(duty[2]), exp_c[n]);
            chk($sformatf("t4min.dir%0d", n), int'(dir[2]), dir_c[n]);
        end
        abort_txn(12'd1000, 12'd2000, 1);
        txn(12'd1000, 12'd500, 1'b0);
        chk("t5.dir_kept", int'(dir[2]), 1);
        chk("t5.duty", int'(duty[2]), 20);
        v_smp = 12'd1000; i_smp = 12'd1000; smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        tick();
        tick();
        do_reset(1'b1);
        chk_state("t6.after", 0, 0);
        txn(12'd1000, 12'd1000, 1'b0);
        chk("t6.duty", int'(duty[0]), 130);
        chk("t6.dir", int'(dir[0]), 1);
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) idle_en_low($urandom_range(1, 3));
            else if (r == 1) abort_txn(12'($urandom), 12'($urandom), $urandom_range(1, 2));
            else if (r == 2) begin
                repeat ($urandom_range(1, 3)) tick();
                chk_state("idle_rand", 0, 0);
            end
            else if (r == 3) txn(last_v, last_i, 1'b1);
            else txn(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
